// File: rtl/sfr_access_master_pkg.sv
// -----------------------------------------------------------------------------
// sfr_acc_pkg
// Shared types and constants for the SFR access master.
//   sfr_acc_state_t : access FSM states
//   SFR_SPACE_BASE  : lowest direct address that maps to the SFR space
//   SFR_WR_LAT      : acceptance-to-ack cycles for a write (no verify)
//   SFR_RD_LAT      : acceptance-to-ack cycles for a read
// -----------------------------------------------------------------------------
package sfr_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_DONE
    } sfr_acc_state_t;

    localparam logic [7:0]  SFR_SPACE_BASE = 8'h80;
    localparam int unsigned SFR_WR_LAT     = 2;
    localparam int unsigned SFR_RD_LAT     = 3;

    // Direct addresses below 0x80 are internal RAM, never an SFR.
    function automatic logic in_sfr_space(input logic [7:0] a);
        return (a >= SFR_SPACE_BASE);
    endfunction

endpackage

// File: rtl/sfr_access_master_if.sv
// -----------------------------------------------------------------------------
// sfr_access_master_if
// Bundles the core request/response handshake and the SFR strobe bus.
//   Core side : req, we, bit_op, addr, wdata, wbit -> ack, err, rdata, rbit
//   SFR side  : sfr_addr, en, oe, Bb, position, din, bin -> sfr_hit, dout, bout
// Modports:
//   master : the access master (drives ack/rdata and the SFR strobes)
//   slave  : the environment (core + SFR bank/decoder)
// -----------------------------------------------------------------------------
interface sfr_access_master_if #(
    parameter int unsigned WIDTH = 8
);
    // core request / response
    logic             req;
    logic             we;
    logic             bit_op;
    logic [7:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic             wbit;
    logic             ack;
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic             rbit;
    // SFR strobe bus
    logic [7:0]       sfr_addr;
    logic             sfr_hit;
    logic             en;
    logic             oe;
    logic             Bb;
    logic [WIDTH-1:0] position;
    logic [WIDTH-1:0] din;
    logic             bin;
    logic [WIDTH-1:0] dout;
    logic             bout;

    modport master (
        input  req, we, bit_op, addr, wdata, wbit, sfr_hit, dout, bout,
        output ack, err, rdata, rbit, sfr_addr, en, oe, Bb, position, din, bin
    );

    modport slave (
        output req, we, bit_op, addr, wdata, wbit, sfr_hit, dout, bout,
        input  ack, err, rdata, rbit, sfr_addr, en, oe, Bb, position, din, bin
    );

endinterface

// File: rtl/sfr_access_master_decode.sv
// -----------------------------------------------------------------------------
// sfr_bitaddr_decode
// Maps an 8051 direct byte address or bit address onto the SFR bus fields.
//   i_addr       : direct byte address (byte op) or bit address (bit op)
//   i_bit_op     : 1 = bit access, 0 = byte access
//   o_sfr_addr   : byte address of the owning SFR
//   o_position   : one-hot bit select, all zero for byte ops
//   o_Bb         : 1 = byte, 0 = bit
// -----------------------------------------------------------------------------
module sfr_bitaddr_decode #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [7:0]       i_addr,
    input  logic             i_bit_op,
    output logic [7:0]       o_sfr_addr,
    output logic [WIDTH-1:0] o_position,
    output logic             o_Bb
);

    always_comb begin
        o_sfr_addr = i_addr;
        o_position = '0;
        o_Bb       = 1'b1;
        if (i_bit_op) begin
            // Bit-addressable SFRs sit on 8-byte boundaries; low 3 bits pick the bit.
            o_sfr_addr = {i_addr[7:3], 3'b000};
            o_position = {{(WIDTH-1){1'b0}}, 1'b1} << i_addr[2:0];
            o_Bb       = 1'b0;
        end
    end

endmodule

// File: rtl/sfr_access_master.sv
// -----------------------------------------------------------------------------
// sfr_access_master
// Initiator side of the SFR port: turns core byte/bit read/write requests into
// en/oe strobes on the shared SFR bus and returns the registered SFR data.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : sfr_access_master_if.master (core handshake + SFR strobe bus)
// Optional feature (macro SFR_ACC_VERIFY_EN): every write is followed by a
// read-back; err flags a mismatch and rdata/rbit return the read-back value.
// -----------------------------------------------------------------------------
module sfr_access_master
    import sfr_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sfr_access_master_if.master   bus
);

    sfr_acc_state_t   r_state;
    logic [7:0]       r_sfr_addr;
    logic [WIDTH-1:0] r_position;
    logic             r_Bb;
    logic [WIDTH-1:0] r_din;
    logic             r_bin;
    logic             r_en;
    logic             r_oe;
    logic             r_ack;
    logic             r_err;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rbit;
`ifdef SFR_ACC_VERIFY_EN
    logic             r_we;
`endif

    logic [7:0]       w_dec_addr;
    logic [WIDTH-1:0] w_dec_pos;
    logic             w_dec_Bb;
    logic             w_accept_ok;

    sfr_bitaddr_decode #(.WIDTH(WIDTH)) u_decode (
        .i_addr     (bus.addr),
        .i_bit_op   (bus.bit_op),
        .o_sfr_addr (w_dec_addr),
        .o_position (w_dec_pos),
        .o_Bb       (w_dec_Bb)
    );

    // The decoder answers for the live address while idle, so the hit check
    // and the acceptance decision happen on the same edge.
    assign w_accept_ok  = in_sfr_space(bus.addr) && bus.sfr_hit;
    assign bus.sfr_addr = (r_state == ST_IDLE) ? w_dec_addr : r_sfr_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_sfr_addr <= '0;
            r_position <= '0;
            r_Bb       <= 1'b1;
            r_din      <= '0;
            r_bin      <= 1'b0;
            r_en       <= 1'b0;
            r_oe       <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_rbit     <= 1'b0;
`ifdef SFR_ACC_VERIFY_EN
            r_we       <= 1'b0;
`endif
        end else begin
            // Strobes and ack are single-cycle; they are set on the edge that
            // enters their state so they line up with that state's cycle.
            r_en  <= 1'b0;
            r_oe  <= 1'b0;
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_err <= 1'b0;
                    if (bus.req) begin
                        r_sfr_addr <= w_dec_addr;
                        r_position <= w_dec_pos;
                        r_Bb       <= w_dec_Bb;
                        r_din      <= bus.wdata;
                        r_bin      <= bus.wbit;
`ifdef SFR_ACC_VERIFY_EN
                        r_we       <= bus.we;
`endif
                        if (!w_accept_ok) begin
                            r_state <= ST_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.we) begin
                            r_state <= ST_WRITE;
                            r_en    <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_oe    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
`ifdef SFR_ACC_VERIFY_EN
                    r_state <= ST_READ;
                    r_oe    <= 1'b1;
`else
                    r_state <= ST_DONE;
                    r_ack   <= 1'b1;
                    r_err   <= 1'b0;
`endif
                end
                ST_READ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_Bb) r_rdata <= bus.dout;
                    else      r_rbit  <= bus.bout;
`ifdef SFR_ACC_VERIFY_EN
                    // Read-back compare against the held write data (din/bin).
                    r_err <= r_we && (r_Bb ? (bus.dout != r_din) : (bus.bout != r_bin));
`else
                    r_err <= 1'b0;
`endif
                    r_state <= ST_DONE;
                    r_ack   <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.en       = r_en;
    assign bus.oe       = r_oe;
    assign bus.Bb       = r_Bb;
    assign bus.position = r_position;
    assign bus.din      = r_din;
    assign bus.bin      = r_bin;
    assign bus.ack      = r_ack;
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;
    assign bus.rbit     = r_rbit;

endmodule

// File: tb/tb_sfr_access_master.sv
// -----------------------------------------------------------------------------
// tb_sfr_access_master
// Self-checking bench for sfr_access_master: directed cases followed by
// randomized byte/bit accesses, with an SFR bank model on the strobe bus and
// a transaction-level reference of the SFR contents and expected responses.
// Honors SFR_ACC_VERIFY_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_sfr_access_master;
    import sfr_acc_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sfr_access_master_if #(.WIDTH(8)) bus ();

    sfr_access_master #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- SFR bank environment ----------------
    logic [7:0] sfr_mem [256];
    logic       hit_tab [256];
    logic       force_zero = 1'b0;

    assign bus.sfr_hit = hit_tab[bus.sfr_addr];

    always @(posedge clk) begin
        if (bus.en) begin
            if (bus.Bb) sfr_mem[bus.sfr_addr] = bus.din;
            else begin
                for (int i = 0; i < 8; i++)
                    if (bus.position[i]) sfr_mem[bus.sfr_addr][i] = bus.bin;
            end
        end
        if (bus.oe) begin
            bus.dout <= force_zero ? 8'h00 : sfr_mem[bus.sfr_addr];
            bus.bout <= force_zero ? 1'b0  : |(sfr_mem[bus.sfr_addr] & bus.position);
        end
    end

    // ---------------- reference state ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_rbit  = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_sfr(input logic [7:0] a, input logic [7:0] v);
        sfr_mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic do_access(input logic we, input logic bit_op, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic wbit);
        logic [7:0]  base, exp_pos, obs_rdata;
        logic        ok, exp_err, obs_err, obs_rbit, overlap, strobe_bad;
        int unsigned exp_lat, lat, n_en, n_oe, exp_en, exp_oe;

        base    = bit_op ? {addr[7:3], 3'b000} : addr;
        exp_pos = bit_op ? (8'h01 << addr[2:0]) : 8'h00;
        ok      = (addr >= 8'h80) && hit_tab[base];

        exp_en  = (ok && we) ? 1 : 0;
        exp_oe  = (ok && !we) ? 1 : 0;
        if (!ok) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else if (we) begin
            if (bit_op) ref_mem[base][addr[2:0]] = wbit;
            else        ref_mem[base] = wdata;
`ifdef SFR_ACC_VERIFY_EN
            exp_lat = 4;
            exp_oe  = 1;
            if (bit_op) begin
                exp_rbit = force_zero ? 1'b0 : wbit;
                exp_err  = (exp_rbit != wbit);
            end else begin
                exp_rdata = force_zero ? 8'h00 : wdata;
                exp_err   = (exp_rdata != wdata);
            end
`else
            exp_lat = SFR_WR_LAT;
            exp_err = 1'b0;
`endif
        end else begin
            exp_lat = SFR_RD_LAT;
            exp_err = 1'b0;
            if (bit_op) exp_rbit  = ref_mem[base][addr[2:0]];
            else        exp_rdata = ref_mem[base];
        end

        @(negedge clk);
        bus.we     = we;
        bus.bit_op = bit_op;
        bus.addr   = addr;
        bus.wdata  = wdata;
        bus.wbit   = wbit;
        bus.req    = 1'b1;
        #1 check_eq("idle_sfr_addr", bus.sfr_addr, base);

        @(posedge clk);  // acceptance edge
        lat = 0; n_en = 0; n_oe = 0; overlap = 0; strobe_bad = 0;
        obs_err = 1'b0; obs_rdata = 8'h00; obs_rbit = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.en && bus.oe) overlap = 1'b1;
            if (bus.en) begin
                n_en++;
                if (bus.sfr_addr !== base || bus.position !== exp_pos || bus.Bb !== !bit_op ||
                    (!bit_op && bus.din !== wdata) || (bit_op && bus.bin !== wbit))
                    strobe_bad = 1'b1;
            end
            if (bus.oe) begin
                n_oe++;
                if (bus.sfr_addr !== base || bus.position !== exp_pos || bus.Bb !== !bit_op)
                    strobe_bad = 1'b1;
            end
            if (bus.ack) begin
                lat       = k;
                obs_err   = bus.err;
                obs_rdata = bus.rdata;
                obs_rbit  = bus.rbit;
                bus.req   = 1'b0;
            end
        end
        bus.req = 1'b0;
        check_eq("ack_latency", lat, exp_lat);
        check_eq("err",         obs_err, exp_err);
        check_eq("rdata",       obs_rdata, exp_rdata);
        check_eq("rbit",        obs_rbit, exp_rbit);
        check_eq("en_pulses",   n_en, exp_en);
        check_eq("oe_pulses",   n_oe, exp_oe);
        check_eq("en_oe_overlap", overlap, 0);
        check_eq("strobe_fields", strobe_bad, 0);
        @(negedge clk);
        check_eq("ack_one_cycle", bus.ack, 0);
    endtask

    task automatic check_reset_values(input logic [7:0] live_addr);
        check_eq("rst_ack",      bus.ack, 0);
        check_eq("rst_err",      bus.err, 0);
        check_eq("rst_en",       bus.en, 0);
        check_eq("rst_oe",       bus.oe, 0);
        check_eq("rst_bin",      bus.bin, 0);
        check_eq("rst_rdata",    bus.rdata, 0);
        check_eq("rst_din",      bus.din, 0);
        check_eq("rst_position", bus.position, 0);
        check_eq("rst_Bb",       bus.Bb, 1);
        check_eq("rst_rbit",     bus.rbit, 0);
        check_eq("rst_sfr_addr", bus.sfr_addr, live_addr);
    endtask

    initial begin
        int unsigned acks;
        logic [7:0]  ra;

        for (int i = 0; i < 256; i++) begin
            sfr_mem[i] = 8'($urandom);
            ref_mem[i] = sfr_mem[i];
            hit_tab[i] = ($urandom_range(3) != 0);
        end
        hit_tab[8'hA0] = 1'b1;
        hit_tab[8'hD0] = 1'b1;
        hit_tab[8'h81] = 1'b1;
        hit_tab[8'hE0] = 1'b1;
        hit_tab[8'h30] = 1'b1;   // in the decoder but below SFR space
        hit_tab[8'h90] = 1'b0;   // decoder miss inside the SFR range

        bus.req = 1'b0; bus.we = 1'b0; bus.bit_op = 1'b0;
        bus.addr = 8'h55; bus.wdata = 8'h00; bus.wbit = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_values(8'h55);
        reset = 1'b1;

        // directed cases
        do_access(1'b1, 1'b0, 8'hA0, 8'h5A, 1'b0);   // byte write
        do_access(1'b1, 1'b1, 8'hD3, 8'h00, 1'b1);   // bit write
        set_sfr(8'h81, 8'h07);
        do_access(1'b0, 1'b0, 8'h81, 8'h00, 1'b0);   // byte read
        set_sfr(8'hE0, sfr_mem[8'hE0] | 8'h80);
        do_access(1'b0, 1'b1, 8'hE7, 8'h00, 1'b0);   // bit read
        do_access(1'b0, 1'b0, 8'h30, 8'h00, 1'b0);   // below SFR space
        do_access(1'b1, 1'b0, 8'h90, 8'h11, 1'b0);   // decoder miss
        do_access(1'b0, 1'b0, 8'hA0, 8'h00, 1'b0);   // read back the byte write
        do_access(1'b0, 1'b1, 8'hD3, 8'h00, 1'b0);   // read back the bit write

        // reset in the middle of a read
        @(negedge clk);
        bus.we = 1'b0; bus.bit_op = 1'b0; bus.addr = 8'h81; bus.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 1'b0;
        #1 check_reset_values(8'h81);
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        check_eq("no_ack_after_reset", acks, 0);
        exp_rdata = 8'h00;
        exp_rbit  = 1'b0;
        do_access(1'b0, 1'b0, 8'h81, 8'h00, 1'b0);

`ifdef SFR_ACC_VERIFY_EN
        force_zero = 1'b1;
        do_access(1'b1, 1'b0, 8'hA0, 8'hFF, 1'b0);
        force_zero = 1'b0;
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            if ($urandom_range(3) != 0) ra[7] = 1'b1;
            do_access(1'($urandom), 1'($urandom), ra, 8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sfr_access_master.md
# sfr_access_master

Initiator side of the special-function-register port: accepts byte or bit read/write requests from the core datapath, maps 8051 direct/bit addresses onto the shared SFR strobe bus (`en`/`oe`/`Bb`/`position`/`din`/`bin`), and returns the registered `dout`/`bout` data. It sits between the instruction execution unit and the SFR bank, one instance per SFR bus.

## Interface
- `WIDTH`, 8, SFR data width and `position` one-hot width.
- `clk` input 1 — single clock, all state on rising edge.
- `reset` input 1 — asynchronous, active-low.
- `req` input 1 — request valid, held until `ack`.
- `we` input 1 — 1 write, 0 read.
- `bit_op` input 1 — 1 bit access, 0 byte access.
- `addr` input 8 — direct byte address (byte op) or bit address (bit op).
- `wdata` input WIDTH — byte write data.
- `wbit` input 1 — bit write data.
- `ack` output 1 — one-cycle completion pulse.
- `err` output 1 — valid with `ack`; access rejected or verify mismatch.
- `rdata` output WIDTH — read byte, valid with `ack`, held until the next `ack`.
- `rbit` output 1 — read bit, valid with `ack`, held until the next `ack`.
- `sfr_addr` output 8 — byte address to the SFR decoder.
- `sfr_hit` input 1 — decoder reports that `sfr_addr` is implemented, same cycle.
- `en` output 1 — SFR write strobe.
- `oe` output 1 — SFR output enable.
- `Bb` output 1 — 1 byte, 0 bit.
- `position` output WIDTH — one-hot bit select, all zero for byte ops.
- `din` output WIDTH — byte write data to the SFR.
- `bin` output 1 — bit write data to the SFR.
- `dout` input WIDTH — registered SFR byte output.
- `bout` input 1 — registered SFR bit output.

## Operation
- Address mapping:
  - Byte op: `sfr_addr = addr`, `position = 0`, `Bb = 1`.
  - Bit op: `sfr_addr = {addr[7:3],3'b000}`, `position = 1 << addr[2:0]`, `Bb = 0`.
- In IDLE, `sfr_addr` is driven from the live `addr`. In every other state it comes from the latched request.
- FSM states: IDLE, WRITE, READ, WAIT, DONE.
- IDLE, `req`=1:
  - Latch `we`, `bit_op`, `addr`, `wdata`, `wbit`.
  - If `addr[7]`=0 or `sfr_hit`=0: go to DONE with `err`=1. No strobe is issued.
  - Else go to WRITE if `we`=1, otherwise READ.
- WRITE: `en`=1, `din`/`bin` driven, `oe`=0; next state DONE.
- READ: `oe`=1; next state WAIT.
- WAIT: capture `dout` into `rdata` or `bout` into `rbit`, depending on `Bb`; next state DONE.
- DONE: `ack`=1 for one cycle; next state IDLE.
- `en` and `oe` are never both high. Both are low outside WRITE/READ.
- A read leaves the unused return field (`rbit` for byte ops, `rdata` for bit ops) unchanged.
- `req` still high in IDLE after `ack` is treated as a new request. The core drops `req` in the `ack` cycle unless issuing back-to-back.
- Reset (any time, including mid-access): FSM goes to IDLE and the in-flight access is abandoned with no `ack`.
- Reset values: `ack`, `err`, `en`, `oe`, `bin` = 0; `rdata`, `din`, `position` = 0; `Bb` = 1; `rbit` = 0; `sfr_addr` follows `addr`.

## Timing
- Acceptance edge E0 is the edge on which IDLE samples `req`=1.
- Write: `en` high in cycle E0→E1; SFR updates at E1; `ack` in cycle E1→E2.
- Read: `oe` high E0→E1; SFR registers output at E1; sample at E2; `ack` in cycle E2→E3 with data valid.
- Rejected access: `ack`+`err` in cycle E0→E1.
- Minimum spacing between two `ack`s for back-to-back reads is 4 cycles.

## Configuration
- `SFR_ACC_VERIFY_EN` defined:
  - After WRITE, the FSM runs READ and WAIT, then compares against the latched request: `dout` vs `wdata` (byte) or `bout` vs `wbit` (bit).
  - `err` = mismatch, and `rdata`/`rbit` are updated with the readback.
  - Write `ack` moves to cycle E3→E4.
- Undefined: writes go WRITE→DONE directly with `err`=0.

## Structure
- Package `sfr_acc_pkg`:
  - State enum `sfr_acc_state_t`.
  - Constant `SFR_SPACE_BASE = 8'h80`.
  - Latency constants `SFR_WR_LAT = 2` and `SFR_RD_LAT = 3`.
- Sub-module `sfr_bitaddr_decode`: combinational mapping from `addr`/`bit_op` to `sfr_addr`, `position`, `Bb`.

## Test plan
- Byte write `addr`=8'hA0, `wdata`=8'h5A, `hit`=1 -> `en` for one cycle with `din`=8'h5A and `Bb`=1; `ack` 2 cycles after acceptance; `err`=0.
- Bit write `addr`=8'hD3, `wbit`=1 -> `sfr_addr`=8'hD0, `position`=8'h08, `Bb`=0, `bin`=1.
- Byte read `addr`=8'h81, model `dout`=8'h07 -> `oe` for one cycle; `ack` 3 cycles after acceptance; `rdata`=8'h07.
- Bit read `addr`=8'hE7, model `bout`=1 -> `position`=8'h80; `rbit`=1 with `ack`.
- `addr`=8'h30 or `sfr_hit`=0 -> `ack`+`err` in the next cycle; `en`/`oe` never asserted.
- Reset asserted during WAIT -> `ack` never pulses; all outputs at reset values; a new read after reset release completes normally.
- With `SFR_ACC_VERIFY_EN`: model returns 8'h00 after a write of 8'hFF -> `ack` with `err`=1 four cycles after acceptance.
